// File: rtl/cache_line_ctrl.sv
// Controller for a direct-mapped, read-only cache: tag compare, multi-beat line
// refill from memory, and whole-cache invalidation. Valid bits live in this block.
module cache_line_ctrl #(
    parameter int ADDR_WIDTH   = 32,
    parameter int INDEX_LENGTH = 6,
    parameter int WORD_OFF     = 2,
    parameter int TAG_LENGTH   = ADDR_WIDTH - INDEX_LENGTH - WORD_OFF - 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cpu_req,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr,
    output logic                    cpu_ready,
    input  logic                    flush,
    output logic                    flush_done,
    output logic [INDEX_LENGTH-1:0] tag_index,
    output logic [TAG_LENGTH-1:0]   tag_in,
    output logic                    tag_w_en,
    input  logic [TAG_LENGTH-1:0]   tag_out,
    output logic [INDEX_LENGTH-1:0] data_index,
    output logic [WORD_OFF-1:0]     data_word,
    output logic                    data_w_en,
    output logic                    mem_req,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic                    mem_rvalid
);

    localparam int CACHE_LINE_NUM = 2**INDEX_LENGTH;

    typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, UPDATE} state_t;

    state_t                    state;
    logic [TAG_LENGTH-1:0]     latTag;
    logic [INDEX_LENGTH-1:0]   latIndex;
    logic [WORD_OFF-1:0]       latWord;
    logic [WORD_OFF-1:0]       beatCnt;
    logic [CACHE_LINE_NUM-1:0] validBits;
    logic                      flushPend;
    logic                      flushDoneQ;

    logic [WORD_OFF-1:0]       reqWord;
    logic [INDEX_LENGTH-1:0]   reqIndex;
    logic [TAG_LENGTH-1:0]     reqTag;
    logic                      hit;
    logic                      unusedByteBits;

    // Byte-within-word bits play no part in a word-granular read-only cache.
    assign unusedByteBits = ^cpu_addr[1:0];
    assign reqWord        = cpu_addr[WORD_OFF+1:2];
    assign reqIndex       = cpu_addr[WORD_OFF+2 +: INDEX_LENGTH];
    assign reqTag         = cpu_addr[ADDR_WIDTH-1 -: TAG_LENGTH];

    assign hit = validBits[latIndex] && (tag_out == latTag);

    assign cpu_ready  = (state == LOOKUP) && hit;
    assign flush_done = flushDoneQ;
    assign tag_index  = latIndex;
    assign tag_in     = latTag;
    assign tag_w_en   = (state == UPDATE);
    assign data_index = latIndex;
    assign data_word  = (state == REFILL) ? beatCnt : latWord;
    assign data_w_en  = (state == REFILL) && mem_rvalid;
    assign mem_req    = (state == REFILL);
    assign mem_addr   = {latTag, latIndex, {(WORD_OFF + 2){1'b0}}};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            latTag     <= '0;
            latIndex   <= '0;
            latWord    <= '0;
            beatCnt    <= '0;
            validBits  <= '0;
            flushPend  <= 1'b0;
            flushDoneQ <= 1'b0;
        end else begin
            flushDoneQ <= 1'b0;
            // A flush seen while busy is remembered and served on return to IDLE.
            if (state != IDLE && flush) begin
                flushPend <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (flush || flushPend) begin
                        validBits  <= '0;
                        flushDoneQ <= 1'b1;
                        flushPend  <= 1'b0;
                    end else if (cpu_req) begin
                        latTag   <= reqTag;
                        latIndex <= reqIndex;
                        latWord  <= reqWord;
                        state    <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        state <= IDLE;
                    end else begin
                        beatCnt <= '0;
                        state   <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem_rvalid) begin
                        beatCnt <= beatCnt + 1'b1;
                        if (beatCnt == '1) begin
                            state <= UPDATE;
                        end
                    end
                end
                UPDATE: begin
                    validBits[latIndex] <= 1'b1;
                    state               <= LOOKUP;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_line_ctrl.sv
// Directed bench for cache_line_ctrl with a tag-store model and scoreboard queues
// for expected data-store and tag-store writes.
module tb_cache_line_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_req = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic        cpu_ready;
    logic        flush = 1'b0;
    logic        flush_done;
    logic [5:0]  tag_index;
    logic [21:0] tag_in;
    logic        tag_w_en;
    logic [21:0] tag_out;
    logic [5:0]  data_index;
    logic [1:0]  data_word;
    logic        data_w_en;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rvalid = 1'b0;

    int checks   = 0;
    int failures = 0;

    logic [21:0] tagMem [64] = '{default: '0};
    logic [7:0]  wrQ [$];
    logic [27:0] tagQ [$];

    cache_line_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_ready  (cpu_ready),
        .flush      (flush),
        .flush_done (flush_done),
        .tag_index  (tag_index),
        .tag_in     (tag_in),
        .tag_w_en   (tag_w_en),
        .tag_out    (tag_out),
        .data_index (data_index),
        .data_word  (data_word),
        .data_w_en  (data_w_en),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rvalid (mem_rvalid)
    );

    always #5 clk = ~clk;

    // Tag store: combinational read, write on the rising edge.
    assign tag_out = tagMem[tag_index];
    always @(posedge clk) begin
        if (tag_w_en) tagMem[tag_index] <= tag_in;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every store write is popped against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            check("wr_exclusive", {63'd0, tag_w_en & data_w_en}, 64'd0);
            if (data_w_en) begin
                check("wr_pending", {63'd0, wrQ.size() > 0}, 64'd1);
                if (wrQ.size() > 0) check("wr_idx_word", {56'd0, data_index, data_word}, {56'd0, wrQ.pop_front()});
            end
            if (tag_w_en) begin
                check("tag_pending", {63'd0, tagQ.size() > 0}, 64'd1);
                if (tagQ.size() > 0) check("tag_idx_val", {36'd0, tag_index, tag_in}, {36'd0, tagQ.pop_front()});
                check("memreq_in_update", {63'd0, mem_req}, 64'd0);
            end
        end
    end

    // Issue one request and follow it to cpu_ready. pat gives mem_rvalid per
    // refill cycle (LSB first); flushAt pulses flush in that refill cycle.
    task automatic doReq(input string name, input logic [31:0] addr, input bit expHit,
                         input logic [15:0] pat, input int expRef, input int flushAt);
        int  cyc = 0;
        int  k = 0;
        int  refCyc = 0;
        bit  seen = 1'b0;
        bit  sawReq = 1'b0;
        cpu_req  = 1'b1;
        cpu_addr = addr;
        if (!expHit) begin
            for (int w = 0; w < 4; w++) wrQ.push_back({addr[9:4], 2'(w)});
            tagQ.push_back({addr[9:4], addr[31:10]});
        end
        @(posedge clk);
        while (!seen && cyc < 60) begin
            #1;
            if (mem_req) begin
                mem_rvalid = (k < 16) ? pat[k] : 1'b1;
                flush      = (k == flushAt);
                k++;
            end else begin
                mem_rvalid = 1'b0;
                flush      = 1'b0;
            end
            @(negedge clk);
            cyc++;
            if (mem_req) begin
                if (!sawReq) check({name, "_mem_addr"}, {32'd0, mem_addr}, {32'd0, addr[31:4], 4'h0});
                sawReq = 1'b1;
                refCyc++;
            end
            if (cpu_ready) begin
                seen = 1'b1;
                check({name, "_latency"}, 64'(cyc), expHit ? 64'd1 : 64'(expRef + 3));
                check({name, "_rd_loc"}, {56'd0, data_index, data_word}, {56'd0, addr[9:4], addr[3:2]});
            end
            @(posedge clk);
        end
        check({name, "_ready_seen"}, {63'd0, seen}, 64'd1);
        check({name, "_mem_req"}, {63'd0, sawReq}, {63'd0, !expHit});
        check({name, "_refill_cycles"}, 64'(refCyc), expHit ? 64'd0 : 64'(expRef));
        #1;
        cpu_req    = 1'b0;
        mem_rvalid = 1'b0;
        flush      = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_mem_side", {31'd0, mem_req, mem_addr}, 64'd0);
        check("reset_outputs", {24'd0, cpu_ready, flush_done, tag_index, tag_in, tag_w_en,
                                data_index, data_word, data_w_en}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        doReq("cold_miss", 32'h0000_1040, 1'b0, 16'hFFFF, 4, -1);
        doReq("hit",       32'h0000_1048, 1'b1, 16'hFFFF, 0, -1);
        doReq("conflict",  32'h0000_2040, 1'b0, 16'hFFFF, 4, -1);
        doReq("remiss_waits", 32'h0000_1040, 1'b0, 16'h0059, 7, -1);

        // Flush arrives mid-refill: refill completes, then invalidation.
        doReq("flush_refill", 32'h0000_2040, 1'b0, 16'hFFFF, 4, 1);
        @(negedge clk);
        check("flush_done_early", {63'd0, flush_done}, 64'd0);
        @(negedge clk);
        check("flush_done_pulse", {63'd0, flush_done}, 64'd1);

        // Reset after the second beat abandons the refill.
        @(posedge clk);
        #1;
        cpu_req  = 1'b1;
        cpu_addr = 32'h0000_2040;
        wrQ.push_back({6'd4, 2'd0});
        wrQ.push_back({6'd4, 2'd1});
        @(posedge clk);
        @(posedge clk);
        #1;
        check("post_flush_miss", {63'd0, mem_req}, 64'd1);
        mem_rvalid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_mem_side", {31'd0, mem_req, mem_addr}, 64'd0);
        check("rst_outputs", {24'd0, cpu_ready, flush_done, tag_index, tag_in, tag_w_en,
                              data_index, data_word, data_w_en}, 64'd0);
        mem_rvalid = 1'b0;
        cpu_req    = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        doReq("after_reset", 32'h0000_2040, 1'b0, 16'hFFFF, 4, -1);

        // Flush issued in IDLE invalidates the line just filled.
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("idle_flush_done", {63'd0, flush_done}, 64'd1);
        @(negedge clk);
        check("idle_flush_clear", {63'd0, flush_done}, 64'd0);
        @(posedge clk);
        #1;
        doReq("after_flush", 32'h0000_2040, 1'b0, 16'hFFFF, 4, -1);
        doReq("hit_word3",   32'h0000_204C, 1'b1, 16'hFFFF, 0, -1);

        check("wr_queue_empty", 64'(wrQ.size()), 64'd0);
        check("tag_queue_empty", 64'(tagQ.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
